// File: rtl/stopwatch_core.sv
// Stopwatch control FSM and cascaded centisecond/second/minute/hour time base.
// Counts only in RUN; a one-cycle CLEAR state zeroes the divider and all counters.
module stopwatch_core #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_run_stop,
    input  logic       i_btn_clear,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_running
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int DW  = $clog2(DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_CLEAR
    } state_e;

    state_e          state_q, state_d;
    logic            running_q;
    logic [DW-1:0]   div_q, div_d;
    logic [6:0]      msec_q, msec_d;
    logic [5:0]      sec_q, sec_d;
    logic [5:0]      min_q, min_d;
    logic [4:0]      hour_q, hour_d;
    logic            tick;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOP: begin
                if (i_btn_clear)
                    state_d = ST_CLEAR;
                else if (i_btn_run_stop)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_btn_run_stop)
                    state_d = ST_STOP;
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    assign tick = (state_q == ST_RUN) && (div_q == DIV_MAX);

    // Divider holds in STOP so a partial centisecond resumes on restart.
    always_comb begin
        div_d = div_q;
        if (state_q == ST_CLEAR)
            div_d = '0;
        else if (state_q == ST_RUN)
            div_d = tick ? '0 : div_q + 1'b1;
    end

    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (state_q == ST_CLEAR) begin
            msec_d = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (tick) begin
            if (msec_q != 7'd99) begin
                msec_d = msec_q + 7'd1;
            end else begin
                msec_d = '0;
                if (sec_q != 6'd59) begin
                    sec_d = sec_q + 6'd1;
                end else begin
                    sec_d = '0;
                    if (min_q != 6'd59) begin
                        min_d = min_q + 6'd1;
                    end else begin
                        min_d  = '0;
                        hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_STOP;
            running_q <= 1'b0;
            div_q     <= '0;
            msec_q    <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
            div_q     <= div_d;
            msec_q    <= msec_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
        end
    end

    assign o_msec    = msec_q;
    assign o_sec     = sec_q;
    assign o_min     = min_q;
    assign o_hour    = hour_q;
    assign o_running = running_q;

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Control unit plus time-base datapath for the stopwatch.
- Consumes the single-cycle debounced button pulses from the button debounce stage (one instance per button).
- Runs an FSM (STOP/RUN/CLEAR) and a cascaded centisecond/second/minute/hour counter driven by an internal tick divider.
- Outputs feed the display formatting / FND stage.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- TICK_HZ, 100: count resolution in Hz (centiseconds). DIV = CLK_FREQ/TICK_HZ; must be an integer ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_btn_run_stop  in  1  run/stop request; single-cycle pulse from debounce.
- i_btn_clear  in  1  clear request; single-cycle pulse from debounce.
- o_msec  out  7  centiseconds, 0..99.
- o_sec  out  6  seconds, 0..59.
- o_min  out  6  minutes, 0..59.
- o_hour  out  5  hours, 0..23.
- o_running  out  1  high while FSM is in RUN.

Behaviour:
- One clock; reset asynchronous, active-high.
- Reset values: FSM = STOP, divider = 0, all time outputs = 0, o_running = 0.
- FSM states: STOP, RUN, CLEAR. Next state is registered; a pulse sampled at edge N changes state at edge N.
- STOP:
  - i_btn_clear=1 -> CLEAR.
  - Otherwise i_btn_run_stop=1 -> RUN.
  - Clear has priority if both pulses are high in the same cycle.
- RUN:
  - i_btn_run_stop=1 -> STOP.
  - i_btn_clear is ignored; stays RUN.
- CLEAR: unconditional -> STOP after exactly one cycle. Buttons in this cycle are ignored.
- o_running is registered and equals (state==RUN). It rises on the same edge the FSM enters RUN.
- Tick divider (width $clog2(DIV)):
  - Increments only in RUN.
  - Wraps DIV-1 -> 0.
  - Holds its value in STOP, so a partial centisecond resumes on restart.
  - Forced to 0 in CLEAR.
- tick = (state==RUN) && (divider==DIV-1). It is combinational and internal.
- On an edge where tick=1:
  - o_msec increments; 99 -> 0 with carry.
  - Carry into o_sec; 59 -> 0 with carry.
  - Carry into o_min; 59 -> 0 with carry.
  - Carry into o_hour; 23 -> 0, no further carry (full rollover to 00:00:00.00).
- Counters hold in STOP. All time counters are forced to 0 on the edge leaving CLEAR.
- Run->stop on the same edge as a tick: the tick increment is applied, then counting halts.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Pulses during reset are lost.
- Time outputs are direct register outputs with no combinational path from inputs.

Test Plan:
- Use CLK_FREQ=1000, TICK_HZ=100 (DIV=10) for all directed tests.
- Reset release, no buttons for 50 cycles -> all outputs 0, o_running=0.
- Run pulse at cycle 5 -> o_running=1 from the next edge. After 10 RUN cycles o_msec=1; after 1000 RUN cycles o_msec=0, o_sec=1.
- Run pulse, 37 RUN cycles, stop pulse, idle 100 cycles, run pulse, 3 cycles -> o_msec stays 3 during STOP. It becomes 4 exactly 3 cycles after restart (divider held at 7).
- Clear pulse while RUN -> ignored, counting continues. Stop, then clear -> one CLEAR cycle, then all time outputs 0 and o_running=0. Run again -> o_msec=1 after 10 cycles.
- Simultaneous run+clear pulses in STOP -> CLEAR taken, o_running stays 0, counters zeroed.
- Preload via run to 23:59:59.99 (or force), one more tick -> o_hour=0, o_min=0, o_sec=0, o_msec=0. Assert reset mid-RUN -> outputs 0 immediately, not at the next clock edge.
